// File: rtl/button_conditioner.sv
// Button conditioner: multi-channel synchronizer + tick-sampled debouncer
// with press, release and optional long-press pulse outputs.
// One sample counter is shared by all channels. Everything else is per channel.
module button_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150,
  parameter int LONG_CNT_MAX   = 0,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press_pulse
);

  localparam int SC_W = (SAMPLE_CNT_MAX > 2) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int PC_W = (PULSE_CNT_MAX > 1) ? $clog2(PULSE_CNT_MAX + 1) : 1;
  localparam int LC_W = (LONG_CNT_MAX > 1) ? $clog2(LONG_CNT_MAX + 1) : 1;

  localparam logic [SC_W-1:0]  SAMPLE_LAST = SC_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [PC_W-1:0]  PULSE_TOP   = PC_W'(PULSE_CNT_MAX);
  localparam logic [LC_W-1:0]  LONG_TOP    = LC_W'(LONG_CNT_MAX);
  // The synchronizer resets to the released level of the button so that an
  // active-low input does not look pressed while the flops refill.
  localparam logic [WIDTH-1:0] SYNC_IDLE   = {WIDTH{ACTIVE_LOW}};

  // Parameter legality, reported during elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("button_conditioner: WIDTH must be >= 1 (got %0d)", WIDTH);
  end
  if (SAMPLE_CNT_MAX < 2) begin : g_bad_sample
    $error("button_conditioner: SAMPLE_CNT_MAX must be >= 2 (got %0d)", SAMPLE_CNT_MAX);
  end
  if (PULSE_CNT_MAX < 1) begin : g_bad_pulse
    $error("button_conditioner: PULSE_CNT_MAX must be >= 1 (got %0d)", PULSE_CNT_MAX);
  end
  if (LONG_CNT_MAX < 0) begin : g_bad_long
    $error("button_conditioner: LONG_CNT_MAX must be >= 0 (got %0d)", LONG_CNT_MAX);
  end

  // Saturating increment of the debounce counter.
  function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] v);
    return (v == PULSE_TOP) ? v : v + PC_W'(1);
  endfunction

  // Saturating increment of the long-press hold counter.
  function automatic logic [LC_W-1:0] hold_inc(input logic [LC_W-1:0] v);
    return (v == LONG_TOP) ? v : v + LC_W'(1);
  endfunction

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] s;
  logic [SC_W-1:0]  sample_cnt;
  logic             tick;

  // Two-flop synchronizer for every raw input bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= SYNC_IDLE;
      sync_p1 <= SYNC_IDLE;
    end else begin
      sync_p0 <= glitchy_signal;
      sync_p1 <= sync_p0;
    end
  end

  // Polarity fix-up after synchronization: s is always active-high.
  assign s = sync_p1 ^ SYNC_IDLE;

  // Shared sample counter. Tick marks the last count of each period.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + SC_W'(1);
    end
  end

  assign tick = (sample_cnt == SAMPLE_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [PC_W-1:0] sat_cnt;
    logic            level_next;
    logic            level_q;
    logic            press_q;
    logic            release_q;

    // Count consecutive high samples. A single low sample restarts the count.
    always_ff @(posedge clk) begin
      if (rst) begin
        sat_cnt <= '0;
      end else if (tick) begin
        sat_cnt <= s[i] ? sat_inc(sat_cnt) : '0;
      end
    end

    assign level_next = (sat_cnt == PULSE_TOP);

    // Register the debounced level and derive edge pulses from it.
    // A reset simply clears the level, so it never produces a release pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= level_next;
        press_q   <= level_next & ~level_q;
        release_q <= ~level_next & level_q;
      end
    end

    assign debounced_signal[i] = level_q;
    assign press_pulse[i]      = press_q;
    assign release_pulse[i]    = release_q;

    if (LONG_CNT_MAX > 0) begin : g_long
      logic [LC_W-1:0] hold_cnt;
      logic            long_q;

      // Count ticks while held. The pulse fires on the edge that reaches the
      // top value; the counter then saturates, so it fires once per press.
      always_ff @(posedge clk) begin
        if (rst) begin
          hold_cnt <= '0;
          long_q   <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (!level_q) begin
            hold_cnt <= '0;
          end else if (tick) begin
            hold_cnt <= hold_inc(hold_cnt);
            long_q   <= (hold_cnt == LONG_TOP - LC_W'(1));
          end
        end
      end

      assign long_press_pulse[i] = long_q;
    end else begin : g_no_long
      assign long_press_pulse[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner. WIDTH=2, SAMPLE_CNT_MAX=10,
// PULSE_CNT_MAX=4, LONG_CNT_MAX=8.
// Extra instances: an ACTIVE_LOW=1 copy driven with inverted inputs, and a
// LONG_CNT_MAX=0 copy.
//
// Timing model used for the expected indices. Inputs change 1 ns after a
// rising edge, and outputs are sampled 1 ns after the next edge. E0 is the
// last reset edge and Ek is the k-th edge after it. The sample counter
// ticks on E10, E20, ...
// An input driven just after Ea reaches s during the cycle before E(a+3).
// Each scenario starts at since_rst % 10 == 6, so the sample edges look at
// inputs whose index i satisfies i % 10 == 1.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] g   = 2'b00;
  logic [1:0] g_n;
  int         since_rst = 0;
  int         checks = 0;
  int         passed = 0;

  logic [1:0] deb, prs, rel, lng;
  logic [1:0] al_deb, al_prs, al_rel, al_lng;
  logic [1:0] nl_deb, nl_prs, nl_rel, nl_lng;

  assign g_n = ~g;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) since_rst <= 0;
    else     since_rst <= since_rst + 1;
  end

  button_conditioner #(
    .WIDTH(2), .SAMPLE_CNT_MAX(10), .PULSE_CNT_MAX(4), .LONG_CNT_MAX(8), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .glitchy_signal(g),
    .debounced_signal(deb), .press_pulse(prs), .release_pulse(rel), .long_press_pulse(lng)
  );

  button_conditioner #(
    .WIDTH(2), .SAMPLE_CNT_MAX(10), .PULSE_CNT_MAX(4), .LONG_CNT_MAX(8), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .glitchy_signal(g_n),
    .debounced_signal(al_deb), .press_pulse(al_prs), .release_pulse(al_rel), .long_press_pulse(al_lng)
  );

  button_conditioner #(
    .WIDTH(2), .SAMPLE_CNT_MAX(10), .PULSE_CNT_MAX(4), .LONG_CNT_MAX(0), .ACTIVE_LOW(1'b0)
  ) dut_nl (
    .clk(clk), .rst(rst), .glitchy_signal(g),
    .debounced_signal(nl_deb), .press_pulse(nl_prs), .release_pulse(nl_rel), .long_press_pulse(nl_lng)
  );

  // Drive one input vector, then advance to 1 ns after the next rising edge.
  task automatic step(input logic [1:0] v);
    g = v;
    @(posedge clk);
    #1;
  endtask

  // Hold the inputs until the bench sits at phase 6 of the sample period.
  task automatic align();
    for (int k = 0; k < 20 && (since_rst % 10) != 6; k++) step(g);
  endtask

  task automatic test_reset();
    int al_act;
    rst = 1'b1;
    g   = 2'b00;
    repeat (3) step(2'b00);
    checks++; if ({deb, prs, rel, lng} !== 8'h00) $display("FAIL reset_outputs: got %h expected 00", {deb, prs, rel, lng}); else passed++;
    checks++; if ({al_deb, al_prs, al_rel, al_lng} !== 8'h00) $display("FAIL reset_outputs_al: got %h expected 00", {al_deb, al_prs, al_rel, al_lng}); else passed++;
    checks++; if ({nl_deb, nl_prs, nl_rel, nl_lng} !== 8'h00) $display("FAIL reset_outputs_nl: got %h expected 00", {nl_deb, nl_prs, nl_rel, nl_lng}); else passed++;
    rst = 1'b0;
    al_act = 0;
    for (int k = 0; k < 60; k++) begin
      step(2'b00);
      if ({al_deb, al_prs, al_rel, al_lng} != 8'h00) al_act++;
    end
    checks++; if (al_act !== 0) $display("FAIL active_low_idle: active cycles %0d expected 0", al_act); else passed++;
  endtask

  // Toggle 10 clocks, then high 30 clocks, then low 50 clocks: never debounces.
  task automatic test_glitch();
    int act;
    act = 0;
    align();
    for (int i = 0; i < 90; i++) begin
      step({1'b0, (i < 10) ? (i % 2 == 0) : (i < 40)});
      if ({deb[0], prs[0], rel[0], lng[0]} != 4'h0) act++;
    end
    checks++; if (act !== 0) $display("FAIL glitch_rejected: active cycles %0d expected 0", act); else passed++;
  endtask

  // Toggle 10 clocks, then high 50 clocks. Samples land on i = 11, 21, 31, 41,
  // so the count reaches 4 on E(a+44) and the debounced level is seen at i=44.
  task automatic test_press();
    int first, presses, drops, al_first, al_presses;
    first = -1; presses = 0; drops = 0; al_first = -1; al_presses = 0;
    align();
    for (int i = 0; i < 60; i++) begin
      step({1'b0, (i < 10) ? (i % 2 == 0) : 1'b1});
      if (deb[0] && first < 0) first = i;
      if (!deb[0] && first >= 0) drops++;
      if (prs[0]) presses++;
      if (al_deb[0] && al_first < 0) al_first = i;
      if (al_prs[0]) al_presses++;
    end
    checks++; if (first !== 44) $display("FAIL press_latency: got index %0d expected 44", first); else passed++;
    checks++; if (presses !== 1) $display("FAIL press_count: got %0d expected 1", presses); else passed++;
    checks++; if (drops !== 0) $display("FAIL press_held: dropped cycles %0d expected 0", drops); else passed++;
    checks++; if (deb[0] !== 1'b1) $display("FAIL press_level_end: got %b expected 1", deb[0]); else passed++;
    checks++; if (al_first !== 44) $display("FAIL active_low_latency: got index %0d expected 44", al_first); else passed++;
    checks++; if (al_presses !== 1) $display("FAIL active_low_press_count: got %0d expected 1", al_presses); else passed++;
  endtask

  // Release right after test_press, still at phase 6. The E70 sample sees
  // 0, so the level falls on E71 (j=4).
  task automatic test_release();
    int fall, releases, rises, presses;
    fall = -1; releases = 0; rises = 0; presses = 0;
    for (int j = 0; j < 63; j++) begin
      step(2'b00);
      if (!deb[0] && fall < 0) fall = j;
      if (deb[0] && fall >= 0) rises++;
      if (rel[0]) releases++;
      if (prs[0]) presses++;
    end
    checks++; if (fall !== 4) $display("FAIL release_latency: got index %0d expected 4", fall); else passed++;
    checks++; if (releases !== 1) $display("FAIL release_count: got %0d expected 1", releases); else passed++;
    checks++; if (rises !== 0 || presses !== 0) $display("FAIL release_stays_low: rises %0d presses %0d expected 0 0", rises, presses); else passed++;
  endtask

  // High for 200 clocks. The press is seen at i=34, and the hold count
  // steps on E(a+44) .. E(a+114). The long pulse is seen at i=113, so the
  // span from press to long pulse is 80 cycles inclusive.
  task automatic test_long_press();
    int p_idx, l_idx, longs, nl_longs, presses;
    p_idx = -1; l_idx = -1; longs = 0; nl_longs = 0;
    align();
    for (int i = 0; i < 200; i++) begin
      step(2'b01);
      if (prs[0] && p_idx < 0) p_idx = i;
      if (lng[0]) begin
        longs++;
        if (l_idx < 0) l_idx = i;
      end
      if (nl_lng != 2'b00) nl_longs++;
    end
    checks++; if (p_idx !== 34) $display("FAIL long_press_edge: got index %0d expected 34", p_idx); else passed++;
    checks++; if (l_idx !== 113) $display("FAIL long_pulse_time: got index %0d expected 113", l_idx); else passed++;
    checks++; if (longs !== 1) $display("FAIL long_pulse_count: got %0d expected 1", longs); else passed++;
    checks++; if (nl_longs !== 0) $display("FAIL long_disabled: got %0d expected 0", nl_longs); else passed++;
    repeat (30) step(2'b00);
    // A short hold of 60 clocks produces a press but no long pulse.
    longs = 0; presses = 0;
    align();
    for (int i = 0; i < 60; i++) begin
      step(2'b01);
      if (lng[0]) longs++;
      if (prs[0]) presses++;
    end
    checks++; if (presses !== 1 || longs !== 0) $display("FAIL short_hold: presses %0d longs %0d expected 1 0", presses, longs); else passed++;
    repeat (30) step(2'b00);
  endtask

  // ch0 held high while ch1 toggles every clock. ch1 is 0 at every odd
  // index, which is where every sample lands, so ch1 never counts.
  task automatic test_independent();
    int first, presses, ch1_act;
    first = -1; presses = 0; ch1_act = 0;
    align();
    for (int i = 0; i < 50; i++) begin
      step({(i % 2 == 0) ? 1'b1 : 1'b0, 1'b1});
      if (deb[0] && first < 0) first = i;
      if (prs[0]) presses++;
      if ({deb[1], prs[1], rel[1], lng[1]} != 4'h0) ch1_act++;
    end
    checks++; if (first !== 34 || presses !== 1) $display("FAIL indep_ch0: index %0d presses %0d expected 34 1", first, presses); else passed++;
    checks++; if (ch1_act !== 0) $display("FAIL indep_ch1_quiet: active cycles %0d expected 0", ch1_act); else passed++;
  endtask

  // Reset for one clock while ch0 is debounced high. The input stays high.
  // The synchronizer refills by E2 and samples land on E10 .. E40, so the
  // level returns on E41 (j=40).
  task automatic test_reset_mid_press();
    int first, releases, presses;
    first = -1; releases = 0; presses = 0;
    checks++; if (deb[0] !== 1'b1) $display("FAIL mid_press_precondition: got %b expected 1", deb[0]); else passed++;
    rst = 1'b1;
    step(2'b01);
    rst = 1'b0;
    checks++; if ({deb, prs, rel, lng} !== 8'h00) $display("FAIL mid_press_reset: got %h expected 00", {deb, prs, rel, lng}); else passed++;
    for (int j = 0; j < 60; j++) begin
      step(2'b01);
      if (deb[0] && first < 0) first = j;
      if (rel[0]) releases++;
      if (prs[0]) presses++;
    end
    checks++; if (first !== 40) $display("FAIL mid_press_relatch: got index %0d expected 40", first); else passed++;
    checks++; if (releases !== 0 || presses !== 1) $display("FAIL mid_press_pulses: releases %0d presses %0d expected 0 1", releases, presses); else passed++;
    repeat (20) step(2'b00);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_release();
    test_long_press();
    test_independent();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
